// File: rtl/handshake_arb_pkg.sv
// Shared constants, source-index type and pointer wrap helper for the handshake arbiter.
// No logic of its own; imported by the picker and the arbiter top.
// Backpressure: not applicable.
package handshake_arb_pkg;

    localparam int N_DEF     = 3;
    localparam int WIDTH_DEF = 4;
    localparam int SRC_W_DEF = $clog2(N_DEF);

    typedef logic [SRC_W_DEF-1:0] src_t;

    // Explicit compare instead of modulo so non-power-of-two N wraps cleanly.
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Rotate-priority picker: first set req bit at or above ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the grant.
module handshake_rr_pick #(
    parameter int N     = 3,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] grant_idx,
    output logic             grant_vld
);

    int idx;

    // Scan from farthest to nearest so the nearest match to ptr is written last.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one OR/AND-reduce output register among N ready/valid requesters.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle while out_ready is high.
// Backpressure: out_valid && !out_ready holds the register and drops every in_ready. HANDSHAKE_ARB_ASSERT_EN adds checks.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SRC_W = $clog2(N)
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SRC_W-1:0]   out_src,
    output logic               out_orr,
    output logic               out_andr
);

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_vld;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] pick_data;

    handshake_rr_pick #(
        .N     (N),
        .SRC_W (SRC_W)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    assign free      = !out_valid || out_ready;
    // The reset input arrives already synchronised upstream, so it doubles as the grant enable.
    assign xfer      = ASYNCRESETN && free && pick_vld;
    assign pick_data = in_data[pick_idx*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_orr   <= 1'b0;
            out_andr  <= 1'b0;
        end else if (xfer) begin
            ptr       <= SRC_W'(next_ptr(int'(pick_idx), N));
            out_valid <= 1'b1;
            out_data  <= pick_data;
            out_src   <= pick_idx;
            out_orr   <= |pick_data;
            out_andr  <= &pick_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HANDSHAKE_ARB_ASSERT_EN
    logic [3:0] starve_cnt [N];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < N; i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || in_ready[i]) begin
                    starve_cnt[i] <= '0;
                end else if (xfer) begin
                    starve_cnt[i] <= starve_cnt[i] + 4'd1;
                end
            end
        end
    end

    a_onehot_ready: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(in_ready));
    a_hold_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src));
    a_reduce: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        out_valid |-> (out_orr === |out_data) && (out_andr === &out_data));

    for (genvar g = 0; g < N; g++) begin : g_fair
        a_fair: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            starve_cnt[g] < 4'(N));
    end
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: vector table, hand sequences, random vs model.
module tb_handshake_rr_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 4;

    logic               CLK;
    logic               ASYNCRESETN;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_src;
    logic               out_orr;
    logic               out_andr;

    handshake_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_orr     (out_orr),
        .out_andr    (out_andr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state kept as plain integers, pick by modulo scan.
    int          m_ptr;
    logic        m_vld;
    logic [3:0]  m_data;
    int          m_src;
    int          m_wait [N];

    task automatic model_reset();
        m_ptr = 0; m_vld = 1'b0; m_data = 4'h0; m_src = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input logic r);
        if (m_vld && !r) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic r);
        int g;
        g = model_pick(v, r);
        if (g >= 0) begin
            chk("fairness", m_wait[g] <= N - 1, 1);
            for (int i = 0; i < N; i++) begin
                if (i == g) m_wait[i] = 0;
                else if (v[i]) m_wait[i]++;
                else m_wait[i] = 0;
            end
            m_data = d[g*WIDTH +: WIDTH];
            m_src  = g;
            m_vld  = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
    endtask

    // One clock: apply inputs, check in_ready, take the edge, check registered outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic r,
                         output logic [N-1:0] rdy);
        int g;
        in_valid = v; in_data = d; out_ready = r;
        #1;
        g = model_pick(v, r);
        chk("in_ready", in_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        rdy = in_ready;
        @(posedge CLK);
        model_edge(v, d, r);
        #1;
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        chk("out_orr", out_orr, m_data != 4'h0);
        chk("out_andr", out_andr, m_data == 4'hF);
        chk("ptr", dut.ptr, m_ptr);
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [11:0] d;
        logic        r;
        logic [2:0]  e_rdy;
        logic        e_vld;
        logic [3:0]  e_data;
        logic [1:0]  e_src;
        logic        e_orr;
        logic        e_andr;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [N-1:0]       rdy;
        logic [N-1:0]       v;
        logic [N*WIDTH-1:0] d;
        logic               r;

        tbl[0]  = '{3'b111, 12'h90F, 1'b1, 3'b001, 1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 2'd1};
        tbl[1]  = '{3'b111, 12'h90F, 1'b1, 3'b010, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 2'd2};
        tbl[2]  = '{3'b111, 12'h90F, 1'b1, 3'b100, 1'b1, 4'h9, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{3'b111, 12'h90F, 1'b1, 3'b001, 1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 2'd1};
        for (int i = 4; i <= 8; i++)
            tbl[i] = '{3'b111, 12'h90F, 1'b0, 3'b000, 1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 2'd1};
        tbl[9]  = '{3'b111, 12'h90F, 1'b1, 3'b010, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 2'd2};
        tbl[10] = '{3'b000, 12'h90F, 1'b1, 3'b000, 1'b0, 4'h0, 2'd1, 1'b0, 1'b0, 2'd2};
        tbl[11] = '{3'b100, 12'h80F, 1'b1, 3'b100, 1'b1, 4'h8, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[12] = '{3'b100, 12'h80F, 1'b1, 3'b100, 1'b1, 4'h8, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{3'b100, 12'h80F, 1'b1, 3'b100, 1'b1, 4'h8, 2'd2, 1'b1, 1'b0, 2'd0};
        tbl[14] = '{3'b010, 12'h85F, 1'b1, 3'b010, 1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 2'd2};
        tbl[15] = '{3'b000, 12'h85F, 1'b0, 3'b000, 1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 2'd2};
        tbl[16] = '{3'b001, 12'h85F, 1'b0, 3'b000, 1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 2'd2};
        tbl[17] = '{3'b001, 12'h85F, 1'b1, 3'b001, 1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 2'd1};

        // Reset held with every requester valid and the consumer ready.
        ASYNCRESETN = 1'b1;
        in_valid    = 3'b111;
        in_data     = 12'h90F;
        out_ready   = 1'b1;
        model_reset();
        #2 ASYNCRESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 3'b000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 4'h0);
        chk("rst_out_src", out_src, 2'd0);
        chk("rst_orr_andr", {out_orr, out_andr}, 2'b00);
        chk("rst_ptr", dut.ptr, 2'd0);
        ASYNCRESETN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, rdy);
            chk("tbl_in_ready", rdy, tbl[i].e_rdy);
            chk("tbl_out", {out_valid, out_data, out_src, out_orr, out_andr},
                {tbl[i].e_vld, tbl[i].e_data, tbl[i].e_src, tbl[i].e_orr, tbl[i].e_andr});
            chk("tbl_ptr", dut.ptr, tbl[i].e_ptr);
        end

        // Randomised traffic; requesters hold valid and data until accepted.
        v = '0; d = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1;
                    d[i*WIDTH +: WIDTH] = 4'($urandom);
                end
            end
            r = ($urandom_range(0, 3) != 0);
            cycle(v, d, r, rdy);
            v = v & ~rdy;
        end

        // Asynchronous reset pulse between edges while the output register is full.
        cycle(3'b111, 12'h90F, 1'b1, rdy);
        chk("pre_pulse_valid", out_valid, 1'b1);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("pulse_out_valid", out_valid, 1'b0);
        chk("pulse_in_ready", in_ready, 3'b000);
        chk("pulse_ptr", dut.ptr, 2'd0);
        model_reset();
        #1 ASYNCRESETN = 1'b1;
        cycle(3'b111, 12'h90F, 1'b1, rdy);
        chk("post_pulse_grant", rdy, 3'b001);
        chk("post_pulse_src", out_src, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
